// File: rtl/sub_arb_pkg.sv
// Shared types and constants for the subtractor arbiter.
// Imported by the arbiter top and the round-robin picker.
package sub_arb_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } sub_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Purely combinational; gnt is one-hot or zero.
module rr_picker #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            any
);

   // Scan from ptr upward, wrapping, and keep only the first hit
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         int k;
         k = (int'(ptr) + i) % NREQ;
         if (!any && req[k]) begin
            any     = 1'b1;
            gnt[k]  = 1'b1;
            gnt_idx = IDW'(k);
         end
      end
   end

endmodule

// File: rtl/sub.sv
// Shared 16-bit subtractor datapath: c = a - b, wrapping.
// Purely combinational; operands come from the arbiter's latches.
module sub
   import sub_arb_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] c
);

   assign c = a - b;

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin arbiter sharing one subtractor among NREQ requesters.
// One operation in flight: IDLE accept, EXEC compute, RESP hand back.
module sub_arbiter
   import sub_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*DATA_W-1:0]   req_a,
   input  logic [NREQ*DATA_W-1:0]   req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [DATA_W-1:0]        rsp_c,
   output logic                     rsp_zero,
   output logic                     rsp_borrow,
   output logic                     busy
);

   sub_arb_state_t    r_state;
   logic [DATA_W-1:0] r_op_a;
   logic [DATA_W-1:0] r_op_b;
   logic [IDW-1:0]    r_op_id;
   logic [IDW-1:0]    r_rr_ptr;
   logic              r_rsp_valid;
   logic [IDW-1:0]    r_rsp_id;
   logic [DATA_W-1:0] r_rsp_c;
   logic              r_rsp_zero;
   logic              r_rsp_borrow;
   logic              r_busy;

   logic [NREQ-1:0]   w_gnt;
   logic [IDW-1:0]    w_gnt_idx;
   logic              w_any;
   logic              w_xfer;
   logic [IDW-1:0]    w_ptr_nxt;
   logic [DATA_W-1:0] w_sel_a;
   logic [DATA_W-1:0] w_sel_b;
   logic [DATA_W-1:0] w_diff;

   rr_picker #(.NREQ(NREQ)) u_pick (
      .req     (req_valid),
      .ptr     (r_rr_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx),
      .any     (w_any)
   );

   // Grants are only offered while idle and out of reset
   assign req_ready = (r_state == IDLE && !rst) ? w_gnt : '0;
   assign w_xfer    = |(req_valid & req_ready);

   assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
   assign w_sel_a   = req_a[w_gnt_idx*DATA_W +: DATA_W];
   assign w_sel_b   = req_b[w_gnt_idx*DATA_W +: DATA_W];

   sub u_sub (
      .a (r_op_a),
      .b (r_op_b),
      .c (w_diff)
   );

   // Sequencer: latch operands, register the result, hold until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_op_id      <= '0;
         r_rr_ptr     <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_c      <= '0;
         r_rsp_zero   <= 1'b0;
         r_rsp_borrow <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  r_op_a   <= w_sel_a;
                  r_op_b   <= w_sel_b;
                  r_op_id  <= w_gnt_idx;
                  r_rr_ptr <= w_ptr_nxt;
                  r_busy   <= 1'b1;
                  r_state  <= EXEC;
               end
            end
            EXEC: begin
               r_rsp_c      <= w_diff;
               r_rsp_zero   <= (w_diff == '0);
               r_rsp_borrow <= (r_op_a < r_op_b);
               r_rsp_id     <= r_op_id;
               r_rsp_valid  <= 1'b1;
               r_state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_c      = r_rsp_c;
   assign rsp_zero   = r_rsp_zero;
   assign rsp_borrow = r_rsp_borrow;
   assign busy       = r_busy;

endmodule

// File: doc/sub_arbiter.md
Name: sub_arbiter

Overview:
Round-robin arbiter and sequencer that shares one instance of the existing 16-bit subtractor datapath `sub` (ports a, b, c; c = a - b) between NREQ requesters. It accepts one request at a time over a valid/ready handshake and latches the operands. It registers the difference and returns it with the requester ID and status flags over a response handshake. It sits between the control units that need subtraction and the single shared `sub` datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester-ID width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  NREQ*16  minuends, flattened; requester i uses bits [16*i+15:16*i].
- req_b  in  NREQ*16  subtrahends, flattened, same packing as req_a.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_c  out  16  registered difference, a - b mod 2^16.
- rsp_zero  out  1  rsp_c == 0.
- rsp_borrow  out  1  unsigned borrow (a < b).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (asynchronous, immediate): state = IDLE, rr_ptr = 0, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_c = 0, rsp_zero = 0, rsp_borrow = 0, busy = 0.
- FSM states:
  - IDLE: a requester is selected; on a handshake go to EXEC.
  - EXEC: 1 cycle; result registers load; go to RESP.
  - RESP: hold until rsp_ready; then go to IDLE.
- Selection in IDLE:
  - Search req_valid starting at rr_ptr, ascending and wrapping modulo NREQ.
  - The first set bit g is the winner; req_ready = one-hot(g), combinational.
  - req_ready is 0 in EXEC and RESP, and 0 in IDLE if no request is valid.
- Handshake: a transfer occurs when req_valid[g] && req_ready[g].
  - On that edge: op_a/op_b latch req_a/req_b slice g, op_id <= g, rr_ptr <= (g+1) mod NREQ.
  - rr_ptr updates only on a transfer.
- EXEC: `sub` inputs are driven only from op_a/op_b.
  - On the edge leaving EXEC: rsp_c <= c, rsp_zero <= (c == 0), rsp_borrow <= (op_a < op_b) unsigned, rsp_id <= op_id.
- RESP:
  - rsp_valid = 1.
  - rsp_* stay stable until the edge where rsp_ready = 1; that edge moves to IDLE and clears rsp_valid.
  - rsp_c/rsp_id keep their values after that (do not care).
- Latency: accept edge T → rsp_valid high from T+2. Minimum 3 cycles per operation (rsp_ready tied high).
- Arithmetic: 16-bit wrap-around only; no saturation and no signed overflow flag.
- Requester rules:
  - Requesters must not make req_valid depend on req_ready.
  - A requester may drop req_valid before it is granted; it is then simply not selected.
  - Operands must be stable only in the accept cycle.
- Simultaneous events:
  - rsp_ready asserted in the same cycle rsp_valid rises: accepted at that edge.
  - A request arriving in RESP waits; at the earliest it is granted in the IDLE cycle after the response handshake.
- Reset mid-operation: the in-flight operation is discarded, no response is produced, and rr_ptr returns to 0.
- No combinational path from rsp_ready to any output. The only combinational path is req_valid → req_ready.

Decomposition:
- Package sub_arb_pkg:
  - DATA_W = 16.
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} sub_arb_state_t.
- Sub-module rr_picker (parameter NREQ; inputs req, ptr; outputs gnt one-hot, gnt_idx, any). Purely combinational.
- One instance of the existing `sub` for the datapath.

Test Plan:
- Single request, requester 0, a = 10, b = 5, rsp_ready = 1 → rsp_valid at T+2 with rsp_c = 5, rsp_id = 0, zero = 0, borrow = 0.
- Requester 2, a = 20, b = 30 → rsp_c = 16'hFFF6, borrow = 1, zero = 0.
- Requester 1, a = 32768, b = 1 → rsp_c = 16'h7FFF, borrow = 0.
- Requester 3, a = 1000, b = 1000 → rsp_c = 0, zero = 1.
- All four req_valid held high after reset → grant order 0, 1, 2, 3, 0. Exactly one req_ready bit per accept, and accept edges are 3 cycles apart.
- Backpressure: rsp_ready = 0 for 5 cycles with a = 1000, b = 999.
  - rsp_valid, rsp_c = 1 and rsp_id are held; req_ready stays 0.
  - After rsp_ready rises, one cycle later the state is IDLE and the next request is granted.
- Reset mid-operation: assert rst during EXEC → outputs are at reset values immediately, no response appears, and the next grant starts from requester 0.
